// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multi-cycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_R_ALU   = 4'd0,
        CL_I_ALU   = 4'd1,
        CL_LW      = 4'd2,
        CL_SW      = 4'd3,
        CL_BEQ     = 4'd4,
        CL_BNE     = 4'd5,
        CL_JR      = 4'd6,
        CL_J       = 4'd7,
        CL_JAL     = 4'd8,
        CL_LUI     = 4'd9,
        CL_ILLEGAL = 4'd10
    } inst_cls_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    localparam logic [3:0] c_ALU_AND  = 4'd0;
    localparam logic [3:0] c_ALU_OR   = 4'd1;
    localparam logic [3:0] c_ALU_XOR  = 4'd2;
    localparam logic [3:0] c_ALU_NOR  = 4'd3;
    localparam logic [3:0] c_ALU_ADD  = 4'd4;
    localparam logic [3:0] c_ALU_SUB  = 4'd5;
    localparam logic [3:0] c_ALU_SLT  = 4'd6;
    localparam logic [3:0] c_ALU_SLL  = 4'd7;
    localparam logic [3:0] c_ALU_SRL  = 4'd8;

    localparam logic [1:0] c_PCS_PC4  = 2'b00;
    localparam logic [1:0] c_PCS_REG  = 2'b01;
    localparam logic [1:0] c_PCS_BR   = 2'b10;
    localparam logic [1:0] c_PCS_JMP  = 2'b11;

    localparam logic [1:0] c_RD_RD    = 2'b00;
    localparam logic [1:0] c_RD_RT    = 2'b01;
    localparam logic [1:0] c_RD_RA    = 2'b10;

    localparam logic [1:0] c_WD_ALU   = 2'b00;
    localparam logic [1:0] c_WD_MEM   = 2'b01;
    localparam logic [1:0] c_WD_PC4   = 2'b10;
    localparam logic [1:0] c_WD_LUI   = 2'b11;

    function automatic logic uses_imm(input inst_cls_t cls);
        return (cls == CL_I_ALU) || (cls == CL_LW) || (cls == CL_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Combinational opcode/funct decoder: class, ALU op, extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 4
) (
    input  logic [OP_W-1:0]     i_op,
    input  logic [OP_W-1:0]     i_funct,
    output inst_cls_t           o_cls,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_imm_s
);

    always_comb begin
        o_cls    = CL_ILLEGAL;
        o_alu_op = c_ALU_ADD;
        o_imm_s  = 1'b0;
        case (i_op)
            c_OP_RTYPE: begin
                case (i_funct)
                    c_FN_ADD: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_ADD; end
                    c_FN_SUB: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_SUB; end
                    c_FN_AND: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_AND; end
                    c_FN_OR:  begin o_cls = CL_R_ALU; o_alu_op = c_ALU_OR;  end
                    c_FN_XOR: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_XOR; end
                    c_FN_NOR: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_NOR; end
                    c_FN_SLT: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_SLT; end
                    c_FN_SLL: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_SLL; end
                    c_FN_SRL: begin o_cls = CL_R_ALU; o_alu_op = c_ALU_SRL; end
                    c_FN_JR:  o_cls = CL_JR;
                    default:  o_cls = CL_ILLEGAL;
                endcase
            end
            c_OP_ADDI: begin o_cls = CL_I_ALU; o_alu_op = c_ALU_ADD; o_imm_s = 1'b1; end
            c_OP_SLTI: begin o_cls = CL_I_ALU; o_alu_op = c_ALU_SLT; o_imm_s = 1'b1; end
            c_OP_ANDI: begin o_cls = CL_I_ALU; o_alu_op = c_ALU_AND; end
            c_OP_ORI:  begin o_cls = CL_I_ALU; o_alu_op = c_ALU_OR;  end
            c_OP_XORI: begin o_cls = CL_I_ALU; o_alu_op = c_ALU_XOR; end
            c_OP_LW:   begin o_cls = CL_LW;    o_imm_s  = 1'b1; end
            c_OP_SW:   begin o_cls = CL_SW;    o_imm_s  = 1'b1; end
            c_OP_BEQ:  begin o_cls = CL_BEQ;   o_alu_op = c_ALU_SUB; end
            c_OP_BNE:  begin o_cls = CL_BNE;   o_alu_op = c_ALU_SUB; end
            c_OP_J:    o_cls = CL_J;
            c_OP_JAL:  o_cls = CL_JAL;
            c_OP_LUI:  o_cls = CL_LUI;
            default:   o_cls = CL_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle IF/ID/EXE/MEM/WB control FSM with instruction reg.
//               Define MC_CTRL_PERF_EN to add cyc_cnt/inst_cnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         Inst_code,
    input  logic                ZF,
    output logic [31:0]         IR,
    output logic                PC_Write,
    output logic [1:0]          PC_s,
    output logic                IR_Write,
    output logic                Reg_Write,
    output logic                Mem_Write,
    output logic [1:0]          rd_rt_s,
    output logic                imm_s,
    output logic                alu_b_s,
    output logic [1:0]          wr_data_s,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic [2:0]          state,
    output logic                illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]         cyc_cnt,
    output logic [31:0]         inst_cnt
`endif
);

    state_t                r_state;
    logic [31:0]           r_ir;
    inst_cls_t             w_cls;
    logic [ALU_OP_W-1:0]   w_dec_alu_op;
    logic                  w_dec_imm_s;
    logic                  w_ir_write;
    logic                  w_pc_write;
    logic                  w_reg_write;
    logic                  w_mem_write;
    logic                  w_illegal;
    logic                  w_taken;

    mc_decode #(
        .OP_W     (OP_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_op     (r_ir[31 -: OP_W]),
        .i_funct  (r_ir[OP_W-1:0]),
        .o_cls    (w_cls),
        .o_alu_op (w_dec_alu_op),
        .o_imm_s  (w_dec_imm_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IF;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_IF: begin
                    r_ir    <= Inst_code;
                    r_state <= S_ID;
                end
                S_ID: begin
                    if ((w_cls == CL_J) || (w_cls == CL_ILLEGAL))
                        r_state <= S_IF;
                    else
                        r_state <= S_EXE;
                end
                S_EXE: begin
                    case (w_cls)
                        CL_LW, CL_SW:          r_state <= S_MEM;
                        CL_BEQ, CL_BNE, CL_JR: r_state <= S_IF;
                        default:               r_state <= S_WB;
                    endcase
                end
                S_MEM:   r_state <= (w_cls == CL_SW) ? S_IF : S_WB;
                default: r_state <= S_IF;
            endcase
        end
    end

    assign w_taken = (w_cls == CL_BEQ) ? ZF : !ZF;

    always_comb begin
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        PC_s        = c_PCS_PC4;
        rd_rt_s     = c_RD_RD;
        wr_data_s   = c_WD_ALU;
        imm_s       = 1'b0;
        alu_b_s     = 1'b0;
        ALU_OP      = c_ALU_ADD;
        case (r_state)
            S_IF: w_ir_write = 1'b1;
            S_ID: begin
                if (w_cls == CL_J) begin
                    w_pc_write = 1'b1;
                    PC_s       = c_PCS_JMP;
                end else if (w_cls == CL_ILLEGAL) begin
                    w_illegal  = 1'b1;
                    w_pc_write = 1'b1;
                end
            end
            default: begin
                // ALU controls persist past EXE so the lw/sw address stays stable
                ALU_OP  = w_dec_alu_op;
                imm_s   = w_dec_imm_s;
                alu_b_s = uses_imm(w_cls);
                if (r_state == S_EXE) begin
                    if ((w_cls == CL_BEQ) || (w_cls == CL_BNE)) begin
                        w_pc_write = 1'b1;
                        PC_s       = w_taken ? c_PCS_BR : c_PCS_PC4;
                    end else if (w_cls == CL_JR) begin
                        w_pc_write = 1'b1;
                        PC_s       = c_PCS_REG;
                    end
                end else if (r_state == S_MEM) begin
                    if (w_cls == CL_SW) begin
                        w_mem_write = 1'b1;
                        w_pc_write  = 1'b1;
                    end
                end else if (r_state == S_WB) begin
                    w_reg_write = 1'b1;
                    w_pc_write  = 1'b1;
                    case (w_cls)
                        CL_R_ALU: rd_rt_s = c_RD_RD;
                        CL_LW: begin
                            rd_rt_s   = c_RD_RT;
                            wr_data_s = c_WD_MEM;
                        end
                        CL_LUI: begin
                            rd_rt_s   = c_RD_RT;
                            wr_data_s = c_WD_LUI;
                        end
                        CL_JAL: begin
                            rd_rt_s   = c_RD_RA;
                            wr_data_s = c_WD_PC4;
                            PC_s      = c_PCS_JMP;
                        end
                        default:  rd_rt_s = c_RD_RT;
                    endcase
                end
            end
        endcase
    end

    // Enables are forced low while reset is held, even though reset state is IF
    assign IR_Write  = w_ir_write  & rst;
    assign PC_Write  = w_pc_write  & rst;
    assign Reg_Write = w_reg_write & rst;
    assign Mem_Write = w_mem_write & rst;
    assign illegal   = w_illegal   & rst;
    assign IR        = r_ir;
    assign state     = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_pc_write)
                r_inst_cnt <= r_inst_cnt + 32'd1;
        end
    end

    assign cyc_cnt  = r_cyc_cnt;
    assign inst_cnt = r_inst_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the R/I/J MIPS core.
- Sits directly downstream of the program-counter/instruction-ROM stage.
  - Consumes Inst_code.
  - Latches Inst_code into an internal instruction register.
  - Drives PC_s and PC_Write back to the PC stage.
  - Drives all datapath enables and selects for the register file, ALU and data memory.
- The PC is written exactly once per instruction, in that instruction's final state. This keeps PC+4 relative to the executing instruction.

Parameters:
- OP_W, 6, width of the opcode and funct fields.
- ALU_OP_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  system clock; the FSM advances on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- Inst_code  in  32  instruction word from the instruction ROM.
- ZF  in  1  ALU zero flag, valid during EXE.
- IR  out  32  registered instruction.
- PC_Write  out  1  PC update enable.
- PC_s  out  2  next-PC select: 00 PC+4, 01 R_Data_A, 10 PC+4+(imm<<2), 11 jump.
- IR_Write  out  1  instruction register load.
- Reg_Write  out  1  register-file write enable.
- Mem_Write  out  1  data-memory write enable.
- rd_rt_s  out  2  destination register select: 00 rd, 01 rt, 10 $31.
- imm_s  out  1  1 sign-extend, 0 zero-extend.
- alu_b_s  out  1  ALU B operand: 0 register, 1 immediate.
- wr_data_s  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4, 11 imm<<16 (lui).
- ALU_OP  out  ALU_OP_W  ALU operation.
- state  out  3  current FSM state, for debug.
- illegal  out  1  one-cycle pulse in ID on an undefined opcode/funct.

Behaviour:
- Reset (rst=0, async):
  - state=IF, IR=0.
  - All enables 0; selects 0; ALU_OP=ADD; illegal=0.
  - Reset asserted mid-instruction aborts it with no PC, register or memory write.
- States: IF(0), ID(1), EXE(2), MEM(3), WB(4).
- Outputs are Moore: a function of state and IR only (ZF is used for the branch PC_Write).
- IF: IR_Write=1; IR loads Inst_code on the next edge; next state ID.
- ID: decode IR[31:26], and IR[5:0] when the opcode is 0.
  - j: PC_Write=1, PC_s=11; next state IF.
  - illegal: illegal=1, PC_Write=1, PC_s=00 (NOP); next state IF.
  - All other instructions: next state EXE.
- EXE:
  - R-ALU ops (add, sub, and, or, xor, nor, slt, sll, srl): ALU_OP from funct, alu_b_s=0; next state WB.
  - I-ALU ops (addi, slti use sign-extend; andi, ori, xori use zero-extend): alu_b_s=1; next state WB.
  - lw/sw: ALU_OP=ADD, imm_s=1, alu_b_s=1; next state MEM.
  - beq/bne: ALU_OP=SUB; PC_Write=1; PC_s=10 if taken (beq: ZF=1; bne: ZF=0), else 00; next state IF.
  - jr: PC_Write=1, PC_s=01; next state IF.
  - jal: next state WB.
  - lui: next state WB.
- MEM:
  - sw: Mem_Write=1, PC_Write=1, PC_s=00; next state IF.
  - lw: address held; next state WB.
- WB: Reg_Write=1, then next state IF.
  - R-type: rd_rt_s=00, PC_s=00.
  - I-ALU: rd_rt_s=01, PC_s=00.
  - lw: rd_rt_s=01, wr_data_s=01, PC_s=00.
  - lui: rd_rt_s=01, wr_data_s=11, PC_s=00.
  - jal: rd_rt_s=10, wr_data_s=10, PC_Write=1, PC_s=11.
  - In every WB case except jal, PC_Write=1 with PC_s=00.
- Latency in cycles: j/illegal 2; beq/bne/jr 3; R/I-ALU/lui/sw/jal 4; lw 5.
- Selects are held stable across the whole state.
- Enables are asserted for exactly one cycle per instruction.
- A write to $0 is not filtered here; the register file ignores it.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[31:0] and inst_cnt[31:0], both cleared by rst.
  - cyc_cnt increments every cycle.
  - inst_cnt increments on every cycle with PC_Write=1, illegal included.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - ALU_OP constants (AND, OR, XOR, NOR, ADD, SUB, SLT, SLL, SRL);
  - PC_s, rd_rt_s and wr_data_s encodings.
- One sub-module, mc_decode: purely combinational. It maps IR to the instruction class, ALU_OP and extension type.
- The FSM and IR register stay in mc_ctrl.

Test Plan:
- Reset:
  - Stimulus: rst=0 mid-EXE of a lw.
  - Required: state=0 immediately; no Reg_Write or Mem_Write; IR=0. After release, IF then ID.
- add $3,$1,$2 (0x00221820):
  - Required states: IF, ID, EXE, WB.
  - EXE: ALU_OP=ADD.
  - WB: Reg_Write=1, rd_rt_s=00, PC_Write=1, PC_s=00.
- lw $5,4($0) (0x8C050004):
  - Required: 5 cycles, with MEM before WB.
  - WB: wr_data_s=01, rd_rt_s=01. Mem_Write never asserted.
- beq (0x10220003):
  - With ZF=1: EXE gives PC_Write=1, PC_s=10.
  - With ZF=0: PC_s=00.
  - Either way the next state is IF after 3 cycles.
- j 0x0000010 (0x08000010):
  - Required: ID gives PC_Write=1, PC_s=11; 2 cycles total.
- jal:
  - Required: WB gives rd_rt_s=10, wr_data_s=10, PC_s=11.
- Opcode 0x3F:
  - Required: illegal=1 for one cycle, PC_s=00, then back to IF.
  - With MC_CTRL_PERF_EN defined: inst_cnt increments by 1.
